// File: rtl/hsmc_pkg.sv
// hsmc_pkg: constants and types shared by the HSMC DAC/ADC rate converters
// (dac_upsampler, DOWNSAMPLER).
//   SAMPLE_W   - converter sample width (unsigned offset binary)
//   MID_SCALE  - offset-binary zero, used as the idle/reset DAC code
//   DEF_WINDOW - fast-clock cycles per slow-rate sample (65 MHz / 200 kHz)
//   DEF_RECIP  - round(2^16 / DEF_WINDOW), Q0.16 ramp step scale
//   state_e    - output sequencer states
package hsmc_pkg;
  localparam int                  SAMPLE_W   = 14;
  localparam logic [SAMPLE_W-1:0] MID_SCALE  = 14'd8192;
  localparam int                  DEF_WINDOW = 325;
  localparam int                  DEF_RECIP  = 202;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

  // Accumulator (Q14.16 in a signed 31-bit word) to DAC code. A positive
  // 31-bit value cannot exceed 2^30-1, so bits [29:16] already saturate at
  // 16383; only the negative side needs an explicit clamp.
  function automatic logic [SAMPLE_W-1:0] acc_to_sample(input logic signed [30:0] acc);
    return acc[30] ? '0 : acc[29:16];
  endfunction
endpackage

// File: rtl/dac_upsampler_sample_fifo.sv
// sample_fifo: small synchronous FIFO for slow-rate samples.
//   clk_i, rst_i  - clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i - write request/data; ignored while full
//   pop_i         - read request; ignored while empty
//   dout_o        - head entry (storage register, valid while !empty_o)
//   full_o        - registered full flag
//   empty_o       - registered empty flag
// DEPTH must be a power of two (pointers wrap naturally).
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    full_q, empty_q;
  logic                    do_push, do_pop;

  // Push qualifies on the pre-pop full flag: a pop in the same cycle as a
  // full-FIFO push frees a slot but does not accept the push.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/dac_upsampler.sv
// dac_upsampler: slow-rate sample stream to one DAC code per CLOCK_IN cycle.
// Each input sample spans WINDOW output cycles, held (default) or linearly
// ramped toward the following sample when LINEAR_INTERP_EN is defined.
//   CLOCK_IN   - single clock, posedge
//   RESET      - synchronous active-high reset
//   DATA_IN    - 14-bit offset-binary sample, DATA_VALID/DATA_READY handshake
//   DATA_READY - !full of the input FIFO (registered flag)
//   ENABLE     - run output sequencing; low returns to IDLE, FIFO kept
//   DATA_OUT   - registered DAC code, mid-scale after reset
//   TRIGGER    - registered, high on the first output cycle of each window
//   UNDERRUN   - sticky, FIFO was empty at a window boundary
// Build option: LINEAR_INTERP_EN (two-sample lookahead + accumulator ramp).
module dac_upsampler
  import hsmc_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int DEPTH  = 4,
  parameter int RECIP  = DEF_RECIP
) (
  input  logic                CLOCK_IN,
  input  logic                RESET,
  input  logic [SAMPLE_W-1:0] DATA_IN,
  input  logic                DATA_VALID,
  output logic                DATA_READY,
  input  logic                ENABLE,
  output logic [SAMPLE_W-1:0] DATA_OUT,
  output logic                TRIGGER,
  output logic                UNDERRUN
);
  localparam int            PW      = $clog2(WINDOW);
  localparam logic [PW-1:0] LAST_PH = PW'(WINDOW - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic [SAMPLE_W-1:0] dout_q, dout_d;
  logic                trig_q, trig_d;
  logic                unr_q, unr_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [SAMPLE_W-1:0] fifo_head;

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk_i   (CLOCK_IN),
    .rst_i   (RESET),
    .push_i  (DATA_VALID),
    .din_i   (DATA_IN),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign DATA_READY = !fifo_full;

`ifdef LINEAR_INTERP_EN
  localparam logic signed [22:0] RECIP_S = 23'(RECIP);

  logic [SAMPLE_W-1:0] nxt_q, nxt_d;
  logic                have_cur_q, have_cur_d;
  logic signed [30:0]  acc_q, acc_d;
  logic signed [14:0]  delta;
  logic signed [22:0]  step;

  assign delta = $signed({1'b0, nxt_q}) - $signed({1'b0, cur_q});
  // Per-cycle increment: delta / WINDOW in Q.16; truncated, not rounded.
  assign step  = 23'(delta) * RECIP_S;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cur_d    = cur_q;
    dout_d   = dout_q;
    trig_d   = 1'b0;
    unr_d    = unr_q;
    fifo_pop = 1'b0;
`ifdef LINEAR_INTERP_EN
    nxt_d      = nxt_q;
    have_cur_d = have_cur_q;
    acc_d      = acc_q;
`endif

    if (!ENABLE) begin
      // Output frozen, phase parked; next enable re-primes from the FIFO.
      state_d = IDLE;
      phase_d = '0;
`ifdef LINEAR_INTERP_EN
      have_cur_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PRIME;
          phase_d = '0;
`ifdef LINEAR_INTERP_EN
          have_cur_d = 1'b0;
`endif
        end

        PRIME: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
`ifdef LINEAR_INTERP_EN
            if (!have_cur_q) begin
              cur_d      = fifo_head;
              have_cur_d = 1'b1;
            end else begin
              nxt_d   = fifo_head;
              state_d = RUN;
              phase_d = '0;
            end
`else
            cur_d   = fifo_head;
            state_d = RUN;
            phase_d = '0;
`endif
          end
        end

        RUN: begin
          trig_d  = (phase_q == '0);
          phase_d = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
`ifdef LINEAR_INTERP_EN
          acc_d  = (phase_q == '0) ? $signed({1'b0, cur_q, 16'd0})
                                   : acc_q + 31'(step);
          dout_d = acc_to_sample(acc_d);
`else
          dout_d = cur_q;
`endif
          if (phase_q == LAST_PH) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
`ifdef LINEAR_INTERP_EN
              cur_d = nxt_q;
              nxt_d = fifo_head;
`else
              cur_d = fifo_head;
`endif
            end else begin
              unr_d = 1'b1;
`ifdef LINEAR_INTERP_EN
              // nxt kept equal to the new cur: flat segment until data returns.
              cur_d = nxt_q;
`endif
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q <= IDLE;
      phase_q <= '0;
      cur_q   <= MID_SCALE;
      dout_q  <= MID_SCALE;
      trig_q  <= 1'b0;
      unr_q   <= 1'b0;
`ifdef LINEAR_INTERP_EN
      nxt_q      <= MID_SCALE;
      have_cur_q <= 1'b0;
      acc_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cur_q   <= cur_d;
      dout_q  <= dout_d;
      trig_q  <= trig_d;
      unr_q   <= unr_d;
`ifdef LINEAR_INTERP_EN
      nxt_q      <= nxt_d;
      have_cur_q <= have_cur_d;
      acc_q      <= acc_d;
`endif
    end
  end

  assign DATA_OUT = dout_q;
  assign TRIGGER  = trig_q;
  assign UNDERRUN = unr_q;
endmodule

// File: tb/tb_dac_upsampler.sv
// Bench for dac_upsampler (default parameters: WINDOW=325, DEPTH=4, RECIP=202).
// Builds with or without LINEAR_INTERP_EN; expected tables follow the build.
// Times t are counted in negedges from the first phase-0 output cycle.
module tb_dac_upsampler;
  import hsmc_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                valid = 1'b0;
  logic                en = 1'b0;
  logic [SAMPLE_W-1:0] din = '0;
  logic                ready, trig, unr;
  logic [SAMPLE_W-1:0] dout;

  always #5 clk = ~clk;

  dac_upsampler dut (
    .CLOCK_IN   (clk),
    .RESET      (rst),
    .DATA_IN    (din),
    .DATA_VALID (valid),
    .DATA_READY (ready),
    .ENABLE     (en),
    .DATA_OUT   (dout),
    .TRIGGER    (trig),
    .UNDERRUN   (unr)
  );

  typedef struct {
    int t;
    int out;
    bit trg;
    bit und;
    bit push;
    int pval;
  } vec_t;

  vec_t vq[$];
  int   seed[$];
  int   n_chk = 0;
  int   n_err = 0;

`ifdef LINEAR_INTERP_EN
  localparam int PRIME_EXTRA = 1;
`else
  localparam int PRIME_EXTRA = 0;
`endif

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cur_t;
`ifdef LINEAR_INTERP_EN
    seed = '{0, 6500, 6500};
    // step = 6500*202 = 1313000; out(p) = floor(p*step / 65536)
    vq.push_back('{0,    0,    1'b1, 1'b0, 1'b0, 0});
    vq.push_back('{1,    20,   1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{2,    40,   1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{100,  2003, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{324,  6491, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{325,  6500, 1'b1, 1'b0, 1'b0, 0});
    vq.push_back('{400,  6500, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{649,  6500, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{650,  6500, 1'b1, 1'b1, 1'b0, 0});
    vq.push_back('{651,  6500, 1'b0, 1'b1, 1'b1, 300});
    vq.push_back('{974,  6500, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{975,  6500, 1'b1, 1'b1, 1'b0, 0});
    // ramp 6500 -> 300: step = -6200*202 = -1252400
    vq.push_back('{1000, 6022, 1'b0, 1'b1, 1'b1, 999});
    vq.push_back('{1075, 4588, 1'b0, 1'b1, 1'b0, 0});
`else
    seed = '{100, 200};
    vq.push_back('{0,    100, 1'b1, 1'b0, 1'b0, 0});
    vq.push_back('{1,    100, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{162,  100, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{324,  100, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{325,  200, 1'b1, 1'b0, 1'b0, 0});
    vq.push_back('{326,  200, 1'b0, 1'b0, 1'b0, 0});
    vq.push_back('{649,  200, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{650,  200, 1'b1, 1'b1, 1'b0, 0});
    vq.push_back('{651,  200, 1'b0, 1'b1, 1'b1, 300});
    vq.push_back('{974,  200, 1'b0, 1'b1, 1'b0, 0});
    vq.push_back('{975,  300, 1'b1, 1'b1, 1'b0, 0});
    vq.push_back('{1000, 300, 1'b0, 1'b1, 1'b1, 999});
    vq.push_back('{1075, 300, 1'b0, 1'b1, 1'b0, 0});
`endif

    // Reset held three cycles with traffic present.
    rst = 1'b1; en = 1'b1; valid = 1'b1; din = 14'd123;
    step(3);
    chk("rst_dout",  dout,  8192);
    chk("rst_ready", ready, 1);
    chk("rst_trig",  trig,  0);
    chk("rst_unr",   unr,   0);

    // Main window sequence.
    rst = 1'b0; valid = 1'b0; en = 1'b1;
    step(1);
    foreach (seed[i]) begin
      din = seed[i][SAMPLE_W-1:0]; valid = 1'b1;
      step(1);
    end
    valid = 1'b0;
    chk("pre_first_dout", dout, 8192);
    chk("pre_first_trig", trig, 0);
    step(1);
    cur_t = 0;
    foreach (vq[i]) begin
      step(vq[i].t - cur_t);
      cur_t = vq[i].t;
      chk($sformatf("dout@t%0d", vq[i].t), dout, vq[i].out);
      chk($sformatf("trig@t%0d", vq[i].t), trig, vq[i].trg);
      chk($sformatf("unr@t%0d",  vq[i].t), unr,  vq[i].und);
      if (vq[i].push) begin
        din = vq[i].pval[SAMPLE_W-1:0]; valid = 1'b1;
        step(1);
        valid = 1'b0;
        cur_t++;
      end
    end

    // Reset at phase 150 with 999 still queued.
    step(1125 - cur_t);
    rst = 1'b1; en = 1'b0;
    step(1);
    chk("midrst_dout",  dout,  8192);
    chk("midrst_trig",  trig,  0);
    chk("midrst_unr",   unr,   0);
    chk("midrst_ready", ready, 1);
    rst = 1'b0;

    // Fill with ENABLE low: ready drops after the 4th (FIFO started empty).
    for (int i = 0; i < 4; i++) begin
      din = 14'(11 * (i + 1)); valid = 1'b1;
      step(1);
      chk($sformatf("fill_ready%0d", i), ready, (i < 3) ? 1 : 0);
    end
    din = 14'd55;
    step(3);
    chk("full_hold_ready", ready, 0);
    en = 1'b1;
    step(1);
    chk("prime_ready", ready, 0);
    step(1);
    chk("after_pop_ready", ready, 1);
    step(1);
    valid = 1'b0;
    step(PRIME_EXTRA);
    chk("fill_w0_dout", dout, 11);
    chk("fill_w0_trig", trig, 1);
    step(325);
    chk("fill_w1_dout", dout, 22);
    chk("fill_w1_trig", trig, 1);
    step(975);
    chk("fill_w4_dout", dout, 55);
    chk("fill_w4_trig", trig, 1);

    // ENABLE low mid-window: output frozen, no further triggers.
    step(10);
    en = 1'b0;
    step(2);
    chk("idle_dout", dout, 55);
    step(330);
    chk("idle_dout_late", dout, 55);
    chk("idle_trig_late", trig, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dac_upsampler.md
# dac_upsampler

Rate-expanding interpolator for the HSMC DAC path: accepts 14-bit unsigned offset-binary samples at the low rate (200 kHz nominal) through a valid/ready handshake and emits one 14-bit sample per CLOCK_IN cycle (65 MHz nominal). Each input sample occupies WINDOW output cycles, either held or linearly ramped toward the next sample. It sits between the sample-generation/processing logic and the DAC data pins. It is the synthesis-side counterpart of DOWNSAMPLER.

## Interface
- WINDOW, 325, output cycles per input sample (65 MHz / 200 kHz); legal range 2..4095
- DEPTH, 4, input FIFO entries; power of two, ≥2
- RECIP, 202, round(2^16 / WINDOW); interpolation step scale, Q0.16

- CLOCK_IN  in  1  single clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- DATA_IN  in  14  input sample, unsigned offset binary
- DATA_VALID  in  1  DATA_IN valid
- DATA_READY  out  1  FIFO can accept; transfer when DATA_VALID && DATA_READY
- ENABLE  in  1  run output sequencing
- DATA_OUT  out  14  registered DAC sample
- TRIGGER  out  1  one-cycle pulse on the first output cycle of each window
- UNDERRUN  out  1  sticky: FIFO empty at a window boundary

## Operation
- Reset values: DATA_OUT=8192 (mid-scale), TRIGGER=0, UNDERRUN=0, DATA_READY=1; FIFO emptied; phase=0; state IDLE.
- FIFO: DATA_READY = !full. Pushes are accepted regardless of ENABLE. Pops happen only at priming or at a window boundary. Push and pop in the same cycle when full: the pop frees the slot, but DATA_READY still reflects the pre-pop full state, so no push occurs.
- States:
  - IDLE: entered on reset or when ENABLE is low. Phase held at 0 and DATA_OUT frozen. Goes to PRIME when ENABLE is high.
  - PRIME: pops the current sample `cur` and, with LINEAR_INTERP_EN, the next sample `nxt` as they become available. Goes to RUN once all required samples are loaded.
  - RUN: phase counts 0..WINDOW-1 and wraps.
    - At the wrap: `cur` ← `nxt` (linear) or ← the FIFO head (hold).
    - If the FIFO is empty at the wrap: set UNDERRUN, keep the old value (hold mode) or set `nxt`=`cur` so delta=0 (linear), and stay in RUN.
- ENABLE low in any state → IDLE next cycle. FIFO contents are kept. UNDERRUN clears on reset only.
- Hold output: DATA_OUT = `cur` for all WINDOW cycles.
- Linear arithmetic:
  - delta = `nxt` − `cur`, signed 15 bits.
  - step = delta × RECIP, signed 23 bits.
  - acc, signed 31 bits: loaded with `cur`<<16 at phase 0, then acc += step each cycle.
  - DATA_OUT = acc[29:16], clamped to 0..16383.
  - Truncation toward −∞; no rounding.

## Timing
- Handshake at edge k (FIFO previously empty, ENABLE high, IDLE): PRIME pops at edge k+1.
  - Hold mode: RUN; DATA_OUT and TRIGGER are valid from edge k+2.
  - Linear mode: needs a second sample; RUN begins 1 cycle after the second sample is popped.
- TRIGGER is registered alongside DATA_OUT: high exactly during phase 0, so there is one pulse every WINDOW cycles in RUN.
- DATA_OUT changes only on CLOCK_IN edges, at most once per cycle; no combinational path from inputs to outputs except DATA_READY (derived from the registered full flag).
- RESET asserted mid-window: all state returns to reset values at that edge; any partially accumulated ramp is discarded.

## Configuration
- LINEAR_INTERP_EN defined: two-sample lookahead and the accumulator ramp described above.
- LINEAR_INTERP_EN undefined: zero-order hold. No `nxt` register, accumulator or multiplier; PRIME needs one sample; RECIP is ignored.

## Structure
- Shared package `hsmc_pkg` holds:
  - the sample width constant (14) and mid-scale constant (8192);
  - the state enum (IDLE, PRIME, RUN);
  - the default WINDOW and RECIP constants, shared with DOWNSAMPLER.
- One sub-module is natural: `sample_fifo` (synchronous FIFO with DEPTH and width parameters, full/empty flags, registered output).

## Test plan
- Reset → DATA_OUT=8192, DATA_READY=1, TRIGGER=0, UNDERRUN=0. Hold RESET 3 cycles during traffic → same values.
- Hold mode, ENABLE=1, push 100 then 200 → DATA_OUT=100 for 325 cycles, then 200. TRIGGER pulses at phase 0 of each window, 325 cycles apart.
- Linear mode, push 0, 6500, 6500 → DATA_OUT=0 at phase 0, 2003 at phase 100, then holds 6500 in the following window (output ≤6500 throughout).
- ENABLE=0, push 5 samples with DEPTH=4 → DATA_READY falls after the 4th; the 5th is not accepted until ENABLE=1 and the first pop.
- Feed one sample then stop → UNDERRUN=1 at the first wrap and DATA_OUT holds. Resume feeding → normal windows continue; UNDERRUN stays 1 until reset.
- Assert RESET at phase 150 in linear mode → next cycle DATA_OUT=8192, FIFO empty, phase 0, IDLE.
